// File: rtl/mmu_req_arbiter.sv
// mmu_req_arbiter: single-outstanding round-robin arbiter (fetch x / data d)
// in front of the shared MMU port. Optional macro: RIVER_MMU_ARB_STATS_EN.
module mmu_req_arbiter #(
  parameter int ABITS           = 64,
  parameter int MemopType_Total = 7,
  parameter bit RR_INIT         = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_x_req_valid,
  output logic                       o_x_req_ready,
  input  logic [ABITS-1:0]           i_x_req_addr,
  input  logic                       i_d_req_valid,
  output logic                       o_d_req_ready,
  input  logic [MemopType_Total-1:0] i_d_req_type,
  input  logic [ABITS-1:0]           i_d_req_addr,
  input  logic [63:0]                i_d_req_wdata,
  input  logic [7:0]                 i_d_req_wstrb,
  input  logic [1:0]                 i_d_req_size,
  output logic [63:0]                o_resp_data,
  output logic                       o_resp_fault,
  output logic                       o_x_resp_valid,
  input  logic                       i_x_resp_ready,
  output logic                       o_d_resp_valid,
  input  logic                       i_d_resp_ready,
  output logic                       o_mmu_req_valid,
  input  logic                       i_mmu_req_ready,
  output logic                       o_mmu_req_x,
  output logic [MemopType_Total-1:0] o_mmu_req_type,
  output logic [ABITS-1:0]           o_mmu_req_addr,
  output logic [63:0]                o_mmu_req_wdata,
  output logic [7:0]                 o_mmu_req_wstrb,
  output logic [1:0]                 o_mmu_req_size,
  input  logic                       i_mmu_resp_valid,
  output logic                       o_mmu_resp_ready,
  input  logic [63:0]                i_mmu_resp_data,
`ifdef RIVER_MMU_ARB_STATS_EN
  output logic [31:0]                o_stat_conflict,
`endif
  input  logic                       i_mmu_resp_fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WACC,
    S_WRSP,
    S_HOLD
  } state_t;

  state_t                     r_state;
  logic                       r_prio;
  logic                       r_owner_x;
  logic                       r_req_valid;
  logic                       r_req_x;
  logic [MemopType_Total-1:0] r_type;
  logic [ABITS-1:0]           r_addr;
  logic [63:0]                r_wdata;
  logic [7:0]                 r_wstrb;
  logic [1:0]                 r_size;
  logic                       r_resp_ready;
  logic [63:0]                r_resp_data;
  logic                       r_resp_fault;
  logic                       r_x_resp_valid;
  logic                       r_d_resp_valid;

  logic w_idle;
  logic w_gnt_x;
  logic w_gnt_d;
  logic w_done;

  // grant is only offered out of reset and in Idle; prio=1 favours d
  assign w_idle  = i_nrst & (r_state == S_IDLE);
  assign w_gnt_x = w_idle & i_x_req_valid
                 & (~i_d_req_valid | ~r_prio);
  assign w_gnt_d = w_idle & i_d_req_valid
                 & (~i_x_req_valid | r_prio);
  assign w_done  = (r_x_resp_valid & i_x_resp_ready)
                 | (r_d_resp_valid & i_d_resp_ready);

  assign o_x_req_ready    = w_gnt_x;
  assign o_d_req_ready    = w_gnt_d;
  assign o_mmu_req_valid  = r_req_valid;
  assign o_mmu_req_x      = r_req_x;
  assign o_mmu_req_type   = r_type;
  assign o_mmu_req_addr   = r_addr;
  assign o_mmu_req_wdata  = r_wdata;
  assign o_mmu_req_wstrb  = r_wstrb;
  assign o_mmu_req_size   = r_size;
  assign o_mmu_resp_ready = r_resp_ready;
  assign o_resp_data      = r_resp_data;
  assign o_resp_fault     = r_resp_fault;
  assign o_x_resp_valid   = r_x_resp_valid;
  assign o_d_resp_valid   = r_d_resp_valid;

  // transaction FSM: grant, forward, collect response, hand it back
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state        <= S_IDLE;
      r_prio         <= RR_INIT;
      r_owner_x      <= 1'b0;
      r_req_valid    <= 1'b0;
      r_req_x        <= 1'b0;
      r_type         <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_size         <= '0;
      r_resp_ready   <= 1'b0;
      r_resp_data    <= '0;
      r_resp_fault   <= 1'b0;
      r_x_resp_valid <= 1'b0;
      r_d_resp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_x | w_gnt_d) begin
            r_state     <= S_WACC;
            r_req_valid <= 1'b1;
            r_owner_x   <= w_gnt_x;
            r_req_x     <= w_gnt_x;
            r_prio      <= w_gnt_x;
            if (w_gnt_x) begin
              r_type  <= '0;
              r_addr  <= i_x_req_addr;
              r_wdata <= '0;
              r_wstrb <= '0;
              r_size  <= 2'd3;
            end else begin
              r_type  <= i_d_req_type;
              r_addr  <= i_d_req_addr;
              r_wdata <= i_d_req_wdata;
              r_wstrb <= i_d_req_wstrb;
              r_size  <= i_d_req_size;
            end
          end
        end
        S_WACC: begin
          if (i_mmu_req_ready) begin
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b1;
            r_state      <= S_WRSP;
          end
        end
        S_WRSP: begin
          if (i_mmu_resp_valid) begin
            r_resp_ready   <= 1'b0;
            r_resp_data    <= i_mmu_resp_data;
            r_resp_fault   <= i_mmu_resp_fault;
            r_x_resp_valid <= r_owner_x;
            r_d_resp_valid <= ~r_owner_x;
            r_state        <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_done) begin
            r_x_resp_valid <= 1'b0;
            r_d_resp_valid <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RIVER_MMU_ARB_STATS_EN
  logic [31:0] r_stat_conflict;

  // saturating count of Idle cycles where both ports compete
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_stat_conflict <= '0;
    end else if (w_idle & i_x_req_valid & i_d_req_valid
                 & (r_stat_conflict != 32'hFFFF_FFFF)) begin
      r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign o_stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// tb_mmu_req_arbiter: directed + random stimulus, scoreboard queues
// of expected MMU requests and owner responses, negedge monitor.
module tb_mmu_req_arbiter;
  localparam int AB = 64;
  localparam int MW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          x_v, d_v;
  logic [AB-1:0] x_a, d_a;
  logic [MW-1:0] d_t;
  logic [63:0]   d_w;
  logic [7:0]    d_s;
  logic [1:0]    d_sz;
  logic          xr, dr, m_rdy, m_rv, m_f;
  logic [63:0]   m_data;

  logic          o_x_req_ready, o_d_req_ready;
  logic [63:0]   o_resp_data;
  logic          o_resp_fault, o_x_resp_valid, o_d_resp_valid;
  logic          o_mmu_req_valid, o_mmu_req_x;
  logic [MW-1:0] o_mmu_req_type;
  logic [AB-1:0] o_mmu_req_addr;
  logic [63:0]   o_mmu_req_wdata;
  logic [7:0]    o_mmu_req_wstrb;
  logic [1:0]    o_mmu_req_size;
  logic          o_mmu_resp_ready;
`ifdef RIVER_MMU_ARB_STATS_EN
  logic [31:0]   o_stat_conflict;
`endif

  mmu_req_arbiter #(
    .ABITS(AB), .MemopType_Total(MW), .RR_INIT(1'b0)
  ) dut (
    .i_clk(clk), .i_nrst(rst_n),
    .i_x_req_valid(x_v), .o_x_req_ready(o_x_req_ready),
    .i_x_req_addr(x_a),
    .i_d_req_valid(d_v), .o_d_req_ready(o_d_req_ready),
    .i_d_req_type(d_t), .i_d_req_addr(d_a),
    .i_d_req_wdata(d_w), .i_d_req_wstrb(d_s),
    .i_d_req_size(d_sz),
    .o_resp_data(o_resp_data), .o_resp_fault(o_resp_fault),
    .o_x_resp_valid(o_x_resp_valid), .i_x_resp_ready(xr),
    .o_d_resp_valid(o_d_resp_valid), .i_d_resp_ready(dr),
    .o_mmu_req_valid(o_mmu_req_valid),
    .i_mmu_req_ready(m_rdy),
    .o_mmu_req_x(o_mmu_req_x), .o_mmu_req_type(o_mmu_req_type),
    .o_mmu_req_addr(o_mmu_req_addr),
    .o_mmu_req_wdata(o_mmu_req_wdata),
    .o_mmu_req_wstrb(o_mmu_req_wstrb),
    .o_mmu_req_size(o_mmu_req_size),
    .i_mmu_resp_valid(m_rv), .o_mmu_resp_ready(o_mmu_resp_ready),
    .i_mmu_resp_data(m_data),
`ifdef RIVER_MMU_ARB_STATS_EN
    .o_stat_conflict(o_stat_conflict),
`endif
    .i_mmu_resp_fault(m_f)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          x;
    logic [MW-1:0] t;
    logic [AB-1:0] a;
    logic [63:0]   w;
    logic [7:0]    s;
    logic [1:0]    sz;
  } req_t;

  typedef struct packed {
    logic        x;
    logic [63:0] data;
    logic        f;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  bit   busy, acc, rspd, last_x, gnt_prev, mrh_prev;
  int   errors = 0;
  int   checks = 0;
  bit   m_pend;
  bit   fix_data;
  logic [63:0] fixed_d;
  logic        fixed_f;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model + scoreboard, sampled mid-cycle
  always @(negedge clk) begin : mon
    req_t r;
    rsp_t p;
    bit   ex_x, ex_d;
    if (!rst_n) begin
      chk("reset_outputs", 64'(|{o_x_req_ready, o_d_req_ready,
          o_resp_data, o_resp_fault, o_x_resp_valid,
          o_d_resp_valid, o_mmu_req_valid, o_mmu_req_x,
          o_mmu_req_type, o_mmu_req_addr, o_mmu_req_wdata,
          o_mmu_req_wstrb, o_mmu_req_size, o_mmu_resp_ready}),
          64'd0);
      req_q.delete();
      rsp_q.delete();
      busy = 0; acc = 0; rspd = 0;
      last_x = 0; gnt_prev = 0; mrh_prev = 0;
    end else begin
      if (gnt_prev)
        chk("req_latency", 64'(o_mmu_req_valid), 64'd1);
      if (mrh_prev)
        chk("resp_latency",
            64'(o_x_resp_valid | o_d_resp_valid), 64'd1);
      gnt_prev = 0;
      mrh_prev = 0;
      chk("resp_onehot", 64'(o_x_resp_valid & o_d_resp_valid),
          64'd0);
      chk("mmu_req_valid", 64'(o_mmu_req_valid),
          64'(busy & !acc));
      chk("mmu_resp_ready", 64'(o_mmu_resp_ready),
          64'(busy & acc & !rspd));
      ex_x = 0;
      ex_d = 0;
      if (!busy) begin
        if (x_v && d_v) begin
          ex_x = !last_x;
          ex_d = last_x;
        end else begin
          ex_x = x_v;
          ex_d = d_v;
        end
      end
      chk("x_req_ready", 64'(o_x_req_ready), 64'(ex_x));
      chk("d_req_ready", 64'(o_d_req_ready), 64'(ex_d));
      if (ex_x || ex_d) begin
        r.x  = ex_x;
        r.t  = ex_x ? '0 : d_t;
        r.a  = ex_x ? x_a : d_a;
        r.w  = ex_x ? '0 : d_w;
        r.s  = ex_x ? '0 : d_s;
        r.sz = ex_x ? 2'd3 : d_sz;
        req_q.push_back(r);
        busy = 1; acc = 0; rspd = 0;
        last_x = ex_x;
        gnt_prev = 1;
      end
      if (o_mmu_req_valid) begin
        if (req_q.size() == 0) begin
          chk("mmu_req_unexpected", 64'd1, 64'd0);
        end else begin
          r = req_q[0];
          chk("mmu_req_addr", o_mmu_req_addr, r.a);
          chk("mmu_req_wdata", o_mmu_req_wdata, r.w);
          chk("mmu_req_ctl",
              64'({o_mmu_req_x, o_mmu_req_type,
                   o_mmu_req_wstrb, o_mmu_req_size}),
              64'({r.x, r.t, r.s, r.sz}));
          if (m_rdy) begin
            void'(req_q.pop_front());
            acc = 1;
          end
        end
      end
      if (o_mmu_resp_ready && m_rv) begin
        p.x    = last_x;
        p.data = m_data;
        p.f    = m_f;
        rsp_q.push_back(p);
        rspd = 1;
        mrh_prev = 1;
      end
      if (o_x_resp_valid || o_d_resp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          p = rsp_q[0];
          chk("x_resp_valid", 64'(o_x_resp_valid), 64'(p.x));
          chk("d_resp_valid", 64'(o_d_resp_valid), 64'(!p.x));
          chk("resp_data", o_resp_data, p.data);
          chk("resp_fault", 64'(o_resp_fault), 64'(p.f));
          if ((o_x_resp_valid && xr) || (o_d_resp_valid && dr)) begin
            void'(rsp_q.pop_front());
            busy = 0;
          end
        end
      end
    end
  end

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  task automatic new_x();
    x_a = {$urandom, $urandom};
  endtask

  task automatic new_d();
    d_t  = MW'($urandom);
    d_a  = {$urandom, $urandom};
    d_w  = {$urandom, $urandom};
    d_s  = 8'($urandom);
    d_sz = 2'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    x_v = 0; d_v = 0; xr = 0; dr = 0;
    m_rdy = 0; m_rv = 0; m_pend = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // one clock of requester + MMU behaviour with % knobs
  task automatic cyc(input int px, input int pd, input int pmr,
                     input int pmv, input int pxr, input int pdr);
    logic xh, dh, mqh, mrh;
    @(negedge clk);
    xh  = x_v & o_x_req_ready;
    dh  = d_v & o_d_req_ready;
    mqh = o_mmu_req_valid & m_rdy;
    mrh = m_rv & o_mmu_resp_ready;
    @(posedge clk);
    #1;
    if (xh) x_v = 0;
    if (dh) d_v = 0;
    if (mqh) m_pend = 1;
    if (mrh) m_pend = 0;
    if (!x_v && pct(px)) begin x_v = 1; new_x(); end
    if (!d_v && pct(pd)) begin d_v = 1; new_d(); end
    m_rdy  = pct(pmr);
    m_rv   = m_pend ? pct(pmv) : pct(pmv / 10);
    m_data = fix_data ? fixed_d : {$urandom, $urandom};
    m_f    = fix_data ? fixed_f : ($urandom_range(0, 3) == 0);
    xr     = pct(pxr);
    dr     = pct(pdr);
  endtask

  initial begin
    int n;
    x_a = '0; d_a = '0; d_t = '0; d_w = '0; d_s = '0; d_sz = '0;
    m_data = '0; m_f = 0; fix_data = 0; fixed_d = '0; fixed_f = 0;
    do_reset();

    // fetch 0x1000 with a known MMU answer
    fix_data = 1;
    fixed_d  = 64'h0123_4567_89AB_CDEF;
    fixed_f  = 0;
    x_a = 64'h1000;
    x_v = 1;
    repeat (8) cyc(0, 0, 100, 100, 100, 100);

    // conflict on first cycle after reset: x, d, then x, d again
    do_reset();
    fix_data = 0;
    new_x(); new_d();
    x_v = 1; d_v = 1;
    repeat (12) cyc(0, 0, 100, 100, 100, 100);
    new_x(); new_d();
    x_v = 1; d_v = 1;
    repeat (12) cyc(0, 0, 100, 100, 100, 100);

    // store held while MMU stalls 5 cycles, then slow consumer
    new_d();
    d_a = 64'h8000_0010;
    d_s = 8'hF0;
    d_v = 1;
    repeat (6) cyc(0, 0, 0, 100, 100, 0);
    cyc(0, 0, 100, 100, 100, 0);
    new_x();
    x_v = 1;
    repeat (5) cyc(0, 0, 100, 100, 100, 0);
    repeat (8) cyc(0, 0, 100, 100, 100, 100);

    // reset while waiting for the MMU answer
    new_x();
    x_v = 1;
    repeat (3) cyc(0, 0, 100, 0, 100, 100);
    rst_n = 1'b0;
    x_v = 0; m_rv = 1; m_pend = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 m_rv = 0;

    // faulting data load
    fix_data = 1;
    fixed_d  = 64'hDEAD_BEEF_0000_0042;
    fixed_f  = 1;
    new_d();
    d_s = 8'h00;
    d_w = '0;
    d_v = 1;
    repeat (8) cyc(0, 0, 100, 100, 100, 100);
    fix_data = 0;

    // random traffic
    repeat (3000) cyc(40, 40, 60, 50, 70, 70);

    // drain outstanding work
    n = 0;
    while ((busy || x_v || d_v) && n < 200) begin
      cyc(0, 0, 100, 100, 100, 100);
      n++;
    end
    chk("drain_timeout", 64'(busy | x_v | d_v), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
